// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for a simple accumulator CPU: fetch, IR load, decode,
// execute/memory/write-back, with ready handshakes and an optional wait timeout.
module control_sequencer #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       reset_ir,
  input  logic       run,
  input  logic [3:0] ir_opcode,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       REIR,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       imem_rd,
  output logic       dmem_rd,
  output logic       dmem_wr,
  output logic       acc_we,
  output logic [1:0] acc_src,
  output logic [2:0] alu_op,
  output logic       flags_we,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StLoad   = 3'd2,
    StDecode = 3'd3,
    StExec   = 3'd4,
    StMem    = 3'd5,
    StWb     = 3'd6,
    StHalt   = 3'd7
  } state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpLda = 4'h2;
  localparam logic [3:0] OpSta = 4'h3;
  localparam logic [3:0] OpAdd = 4'h4;
  localparam logic [3:0] OpSub = 4'h5;
  localparam logic [3:0] OpAnd = 4'h6;
  localparam logic [3:0] OpOr  = 4'h7;
  localparam logic [3:0] OpJmp = 4'h8;
  localparam logic [3:0] OpJz  = 4'h9;
  localparam logic [3:0] OpJc  = 4'hA;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [8:0] WaitLimit = 9'(WAIT_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       waiting;
  logic       timeout;
  state_e     fetch_or_idle;

  // A cycle spent in FETCH/MEM without the matching ready counts as a wait cycle.
  assign waiting = ((state_q == StFetch) && !imem_ready) || ((state_q == StMem) && !dmem_ready);
  // Fires in the WAIT_LIMIT-th consecutive wait cycle.
  assign timeout = waiting && (WaitLimit != 9'd0) && (({1'b0, wait_q} + 9'd1) >= WaitLimit);
  assign fetch_or_idle = run ? StFetch : StIdle;

  always_ff @(posedge clk or posedge reset_ir) begin
    if (reset_ir) begin
      state_q   <= StIdle;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q | timeout;
    wait_d    = 8'd0;
    if (waiting && (wait_q != 8'hFF)) begin
      wait_d = wait_q + 8'd1;
    end else if (waiting) begin
      wait_d = wait_q;
    end

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ready)   state_d = StLoad;
        else if (timeout) state_d = StHalt;
      end
      StLoad: state_d = StDecode;
      StDecode: begin
        case (ir_opcode)
          OpNop:                               state_d = fetch_or_idle;
          OpLdi, OpJmp, OpJz, OpJc:            state_d = StExec;
          OpLda, OpSta, OpAdd, OpSub, OpAnd,
          OpOr:                                state_d = StMem;
          OpHlt:                               state_d = StHalt;
          default:                             state_d = fetch_or_idle;
        endcase
      end
      StExec: state_d = fetch_or_idle;
      StMem: begin
        if (dmem_ready)   state_d = (ir_opcode == OpSta) ? fetch_or_idle : StWb;
        else if (timeout) state_d = StHalt;
      end
      StWb:   state_d = fetch_or_idle;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    REIR     = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    imem_rd  = 1'b0;
    dmem_rd  = 1'b0;
    dmem_wr  = 1'b0;
    acc_we   = 1'b0;
    acc_src  = 2'b00;
    alu_op   = 3'b000;
    flags_we = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      StIdle: ;
      StFetch: imem_rd = 1'b1;
      StLoad: begin
        REIR   = 1'b1;
        pc_inc = 1'b1;
      end
      StDecode: begin
        illegal = (ir_opcode >= 4'hB) && (ir_opcode <= 4'hE);
      end
      StExec: begin
        case (ir_opcode)
          OpLdi: begin
            acc_we  = 1'b1;
            acc_src = 2'b10;
          end
          OpJmp:   pc_load = 1'b1;
          OpJz:    pc_load = zero_flag;
          OpJc:    pc_load = carry_flag;
          default: ;
        endcase
      end
      StMem: begin
        if (ir_opcode == OpSta) dmem_wr = 1'b1;
        else                    dmem_rd = 1'b1;
      end
      StWb: begin
        acc_we = 1'b1;
        if (ir_opcode == OpLda) begin
          acc_src = 2'b01;
        end else begin
          acc_src  = 2'b00;
          alu_op   = {1'b0, ir_opcode[1:0]};
          flags_we = 1'b1;
        end
      end
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (built with WAIT_LIMIT=3).
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset_ir;
  logic       run;
  logic [3:0] ir_opcode;
  logic       zero_flag, carry_flag, imem_ready, dmem_ready;
  logic       REIR, pc_inc, pc_load, imem_rd, dmem_rd, dmem_wr, acc_we;
  logic [1:0] acc_src;
  logic [2:0] alu_op;
  logic       flags_we, illegal, bus_err, halted;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  control_sequencer #(.WAIT_LIMIT(3)) dut (
    .clk       (clk),
    .reset_ir  (reset_ir),
    .run       (run),
    .ir_opcode (ir_opcode),
    .zero_flag (zero_flag),
    .carry_flag(carry_flag),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .REIR      (REIR),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .imem_rd   (imem_rd),
    .dmem_rd   (dmem_rd),
    .dmem_wr   (dmem_wr),
    .acc_we    (acc_we),
    .acc_src   (acc_src),
    .alu_op    (alu_op),
    .flags_we  (flags_we),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .halted    (halted),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // From a FETCH cycle with zero-wait memories, count cycles until the next FETCH/IDLE/HALT.
  task automatic measure(input logic [3:0] op, output int cycles);
    ir_opcode = op;
    cycles = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state == 3'd1 || state == 3'd0 || state == 3'd7) break;
      cycles++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ir = 1'b1;
    @(negedge clk);
    reset_ir = 1'b0;
  endtask

  int lat;
  int pc_pulses;

  initial begin
    reset_ir = 1'b1; run = 1'b0; ir_opcode = 4'h0;
    zero_flag = 1'b0; carry_flag = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_imem_rd", imem_rd, 0);
    check("rst_reir", REIR, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_halted", halted, 0);
    reset_ir = 1'b0;

    // NOP: 0,1,2,3,1
    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; ir_opcode = 4'h0;
    check("nop_idle", state, 0);
    pc_pulses = 0;
    @(negedge clk); check("nop_s1", state, 1); check("nop_imem_rd", imem_rd, 1);
    check("nop_reir_f", REIR, 0); pc_pulses += int'(pc_inc);
    @(negedge clk); check("nop_s2", state, 2); check("nop_reir_l", REIR, 1);
    pc_pulses += int'(pc_inc);
    @(negedge clk); check("nop_s3", state, 3); check("nop_reir_d", REIR, 0);
    pc_pulses += int'(pc_inc);
    @(negedge clk); check("nop_s1b", state, 1); pc_pulses += int'(pc_inc);
    check("nop_pc_inc_cnt", pc_pulses, 1);

    // LDA with dmem_ready delayed by 2 cycles
    ir_opcode = 4'h2; dmem_ready = 1'b0;
    lat = 1;
    @(negedge clk); lat++; check("lda_load", state, 2);
    @(negedge clk); lat++; check("lda_dec", state, 3);
    @(negedge clk); lat++; check("lda_m1", dmem_rd, 1);
    @(negedge clk); lat++; check("lda_m2", dmem_rd, 1);
    @(negedge clk); lat++; check("lda_m3", dmem_rd, 1); check("lda_m3_st", state, 5);
    dmem_ready = 1'b1;
    @(negedge clk); lat++; check("lda_wb", state, 6); check("lda_acc_we", acc_we, 1);
    check("lda_acc_src", acc_src, 1); check("lda_wb_rd", dmem_rd, 0);
    @(negedge clk); check("lda_fetch", state, 1);
    check("lda_latency", lat, 7);

    // SUB write-back controls
    ir_opcode = 4'h5;
    @(negedge clk); @(negedge clk); @(negedge clk);
    @(negedge clk); check("sub_wb", state, 6); check("sub_alu_op", alu_op, 1);
    check("sub_flags_we", flags_we, 1); check("sub_acc_src", acc_src, 0);
    @(negedge clk);

    // JZ not taken / taken
    ir_opcode = 4'h9; zero_flag = 1'b0;
    @(negedge clk); @(negedge clk);
    @(negedge clk); check("jz0_exec", state, 4); check("jz0_pc_load", pc_load, 0);
    @(negedge clk); zero_flag = 1'b1;
    @(negedge clk); @(negedge clk);
    @(negedge clk); check("jz1_exec", state, 4); check("jz1_pc_load", pc_load, 1);
    @(negedge clk); zero_flag = 1'b0;

    // JC taken, LDI exec controls
    ir_opcode = 4'hA; carry_flag = 1'b1;
    @(negedge clk); @(negedge clk);
    @(negedge clk); check("jc1_pc_load", pc_load, 1);
    @(negedge clk); carry_flag = 1'b0; ir_opcode = 4'h1;
    @(negedge clk); @(negedge clk);
    @(negedge clk); check("ldi_acc_we", acc_we, 1); check("ldi_acc_src", acc_src, 2);
    @(negedge clk);

    // Illegal opcode C
    ir_opcode = 4'hC;
    @(negedge clk);
    @(negedge clk); check("ill_dec", state, 3); check("ill_pulse", illegal, 1);
    check("ill_rd", dmem_rd, 0); check("ill_wr", dmem_wr, 0);
    @(negedge clk); check("ill_fetch", state, 1); check("ill_drop", illegal, 0);

    // Latencies with zero-wait memories
    measure(4'h0, lat); check("lat_nop", lat, 3);
    measure(4'hE, lat); check("lat_ill", lat, 3);
    measure(4'h1, lat); check("lat_ldi", lat, 4);
    measure(4'h8, lat); check("lat_jmp", lat, 4);
    measure(4'h3, lat); check("lat_sta", lat, 4);
    measure(4'h4, lat); check("lat_add", lat, 5);
    measure(4'h7, lat); check("lat_or", lat, 5);

    // run=0 during ADD: completes write-back, then IDLE
    ir_opcode = 4'h4;
    @(negedge clk); run = 1'b0;
    @(negedge clk); @(negedge clk);
    @(negedge clk); check("add_wb", state, 6); check("add_acc_we", acc_we, 1);
    check("add_alu_op", alu_op, 0);
    @(negedge clk); check("add_idle", state, 0);
    @(negedge clk); check("add_idle2", state, 0);
    run = 1'b1;
    @(negedge clk); check("resume_fetch", state, 1);

    // Reset mid-MEM during STA
    ir_opcode = 4'h3; dmem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    @(negedge clk); check("sta_mem", state, 5); check("sta_wr", dmem_wr, 1);
    #2 reset_ir = 1'b1;
    #1 check("sta_rst_wr", dmem_wr, 0); check("sta_rst_state", state, 0);
    @(negedge clk); reset_ir = 1'b0; dmem_ready = 1'b1;

    // HLT: halted, stays under run toggling
    ir_opcode = 4'hF;
    @(negedge clk); check("hlt_fetch", state, 1);
    @(negedge clk); @(negedge clk);
    @(negedge clk); check("hlt_state", state, 7); check("hlt_halted", halted, 1);
    check("hlt_bus_err", bus_err, 0);
    run = 1'b0; @(negedge clk); check("hlt_run0", state, 7);
    run = 1'b1; @(negedge clk); check("hlt_run1", state, 7);

    // Fetch timeout: imem_ready stuck low
    do_reset();
    imem_ready = 1'b0; ir_opcode = 4'h0;
    @(negedge clk); check("to_f1", state, 1);
    @(negedge clk); check("to_f2", state, 1);
    @(negedge clk); check("to_f3", state, 1); check("to_f3_err", bus_err, 0);
    @(negedge clk); check("to_halt", state, 7); check("to_bus_err", bus_err, 1);
    check("to_imem_rd", imem_rd, 0); check("to_halted", halted, 1);

    // Ready in the limit cycle wins
    do_reset();
    check("rst_clears_err", bus_err, 0);
    @(negedge clk); check("lim_f1", state, 1);
    @(negedge clk); check("lim_f2", state, 1);
    @(negedge clk); check("lim_f3", state, 1); imem_ready = 1'b1;
    @(negedge clk); check("lim_load", state, 2); check("lim_no_err", bus_err, 0);

    // Data-side timeout on LDA
    ir_opcode = 4'h2; dmem_ready = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    @(negedge clk); check("dto_halt", state, 7); check("dto_err", bus_err, 1);
    check("dto_rd", dmem_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
